fetch_queue_stage: RTL and testbench

Instruction-fetch front end for the five-stage pipelined MIPS CPU. Owns the program counter, issues word reads to the instruction port of the unified memory, and buffers returned instructions with their PC+4 in a small queue. Delivers them to the IF/ID pipeline register through a valid/ready handshake. Taken branches and jumps resolved in MEM arrive as a redirect; the redirect flushes the queue and any in-flight fetch.

---
 rtl/fetch_queue_stage_pkg.sv | 24 ++
 rtl/fetch_queue_stage_if.sv | 30 +++
 rtl/fetch_queue_stage_fifo.sv | 79 +++++++
 rtl/fetch_queue_stage.sv | 119 +++++++++++
 tb/tb_fetch_queue_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch front end: word geometry, the
// queue entry format {instr, pcplus4}, the default reset PC and a word-align
// helper used on redirect targets.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pcplus4;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~WORD_W'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_stage_if
// Bundles the fetch stage's external traffic: the MEM-stage redirect, the
// instruction-memory port and the valid/ready output towards IF/ID.
//   master : the fetch stage (drives imem_req/imem_addr and out_*)
//   slave  : the environment (memory, MEM-stage redirect, IF/ID register)
// -----------------------------------------------------------------------------
interface fetch_queue_stage_if;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pcplus4;

  modport master (
    input  redirect, redirect_pc, imem_data, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pcplus4
  );

  modport slave (
    output redirect, redirect_pc, imem_data, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pcplus4
  );

endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t. Flush has priority over push/pop.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   push, push_data  : write an entry (caller guarantees not full)
//   pop              : retire the head (caller guarantees not empty)
//   flush            : discard all entries at the next edge
//   head             : current head entry (contents undefined when empty)
//   count, empty     : occupancy 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 push_data,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch inferred).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is intentionally not reset; count gates every use of head.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_queue_stage.sv
// -----------------------------------------------------------------------------
// fetch_queue_stage
// Instruction-fetch front end: owns the PC, issues one-cycle-latency word reads,
// queues {instr, pcplus4} and hands them to IF/ID over valid/ready. A redirect
// from MEM flushes the queue and the in-flight response and refetches from the
// target in the same cycle.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : fetch_queue_stage_if.master (redirect, imem_*, out_*)
// Build option: define FETCH_BYPASS_EN to let a response reach the outputs
// combinationally when the queue is empty (1-cycle fetch latency).
// -----------------------------------------------------------------------------
module fetch_queue_stage
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_queue_stage_if.master  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] pc_q,   pc_d;
  logic [WORD_W-1:0] addr_q, addr_d;      // address of the request in flight
  logic              inflight_q, inflight_d;
  logic              discard_q,  discard_d;

  logic              resp_valid, inflight_kept, bypass_hit;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      resp_entry, head_entry, out_entry;
  logic              imem_req_c;
  logic [WORD_W-1:0] imem_addr_c;
  int                credit_used;

  // A response is usable only if nothing since its issue has invalidated it.
  assign inflight_kept = inflight_q && !discard_q && !bus.redirect;
  assign resp_valid    = inflight_kept && !reset;
  assign resp_entry    = '{instr: bus.imem_data, pcplus4: addr_q + WORD_W'(INSTR_BYTES)};

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = resp_valid && fifo_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // A redirect ignores any pop; a bypassed response consumed directly is never pushed.
  assign fifo_pop  = !fifo_empty && bus.out_ready && !bus.redirect && !reset;
  assign fifo_push = resp_valid && !(bypass_hit && bus.out_ready);

  always_comb begin
    // Credit: slots held after this cycle's pop plus the response still owed.
    credit_used = int'(fifo_count) - int'(fifo_pop) + int'(inflight_kept);
    // The redirect flushes the queue, so its request never needs a credit.
    imem_req_c  = !reset && (bus.redirect || (credit_used < DEPTH));
    if (reset)             imem_addr_c = RESET_PC;
    else if (bus.redirect) imem_addr_c = word_align(bus.redirect_pc);
    else                   imem_addr_c = pc_q;
  end

  always_comb begin
    pc_d       = pc_q;
    addr_d     = addr_q;
    inflight_d = imem_req_c;
    // Only needed if a redirect cycle ever failed to issue: the response of the
    // pre-redirect request would then arrive unguarded one cycle later.
    discard_d  = !reset && bus.redirect && !imem_req_c;
    if (reset) begin
      pc_d = RESET_PC;
    end else if (imem_req_c) begin
      pc_d   = imem_addr_c + WORD_W'(INSTR_BYTES);   // wraps modulo 2^32
      addr_d = imem_addr_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (bus.redirect),
    .push_data (resp_entry),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_comb begin
    if (reset)            out_entry = '0;
    else if (!fifo_empty) out_entry = head_entry;
    else if (bypass_hit)  out_entry = resp_entry;
    else                  out_entry = '0;
  end

  assign bus.imem_req    = imem_req_c;
  assign bus.imem_addr   = imem_addr_c;
  assign bus.out_valid   = !reset && (!fifo_empty || bypass_hit);
  assign bus.out_instr   = out_entry.instr;
  assign bus.out_pcplus4 = out_entry.pcplus4;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue_stage
// Directed bench for fetch_queue_stage (default build, DEPTH=4, RESET_PC=0).
// Memory model: word at address A reads as A, one cycle after the request;
// cycles with no request return 32'hDEAD_BEEF so a spurious push shows up.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_fetch_queue_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fetch_queue_stage_if bus ();

  fetch_queue_stage #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.imem_data <= bus.imem_req ? bus.imem_addr : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic valid,
                           input logic [31:0] instr, input logic [31:0] pcplus4);
    check({tag, "_valid"}, {31'b0, bus.out_valid}, {31'b0, valid});
    check({tag, "_instr"}, bus.out_instr, instr);
    check({tag, "_pc4"},   bus.out_pcplus4, pcplus4);
  endtask

  // One reset cycle; returns at the falling edge of cycle 0 with reset low.
  task automatic apply_reset();
    @(negedge clk);
    reset          = 1'b1;
    bus.redirect   = 1'b0;
    bus.out_ready  = 1'b0;
    @(negedge clk);
    reset          = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready   = 1'b0;

    // ---- Reset state ----
    @(negedge clk); #1;
    check("rst_req",  {31'b0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check_out("rst_out", 1'b0, 32'h0, 32'h0);

    // ---- Free run, out_ready high: valid in cycle 2, stream 0,4,8,C ----
    @(negedge clk);
    reset = 1'b0; bus.out_ready = 1'b1; #1;
    check("a_c0_req",  {31'b0, bus.imem_req}, 32'd1);
    check("a_c0_addr", bus.imem_addr, 32'h0);
    check_out("a_c0", 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    check("a_c1_addr", bus.imem_addr, 32'h4);
    check("a_c1_valid", {31'b0, bus.out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check_out($sformatf("a_stream%0d", k), 1'b1, 32'(k * 4), 32'(k * 4 + 4));
    end

    // ---- Back-pressure: out_ready low 10 cycles after first valid ----
    apply_reset();
    bus.out_ready = 1'b0; #1;                 // cycle 0
    repeat (3) @(negedge clk);                // cycle 3
    for (int c = 4; c < 12; c++) begin
      @(negedge clk); #1;
      check($sformatf("b_c%0d_req", c), {31'b0, bus.imem_req}, 32'd0);
      check_out($sformatf("b_c%0d", c), 1'b1, 32'h0, 32'h4);
    end
    @(negedge clk);                           // cycle 12: release
    bus.out_ready = 1'b1; #1;
    check("b_rel_req",  {31'b0, bus.imem_req}, 32'd1);
    check("b_rel_addr", bus.imem_addr, 32'h10);
    check_out("b_rel0", 1'b1, 32'h0, 32'h4);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk); #1;
      check_out($sformatf("b_rel%0d", k), 1'b1, 32'(k * 4), 32'(k * 4 + 4));
    end

    // ---- Redirect with 3 queued entries and one request in flight ----
    apply_reset();
    bus.out_ready = 1'b0;                     // cycle 0
    repeat (3) @(negedge clk);                // cycle 3
    @(negedge clk);                           // cycle 4
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0100; #1;
    check("c_redir_req",  {31'b0, bus.imem_req}, 32'd1);
    check("c_redir_addr", bus.imem_addr, 32'h100);
    @(negedge clk);                           // cycle 5
    bus.redirect = 1'b0; #1;
    check_out("c_flushed", 1'b0, 32'h0, 32'h0);
    check("c_c5_addr", bus.imem_addr, 32'h104);
    @(negedge clk);                           // cycle 6
    bus.out_ready = 1'b1; #1;
    check_out("c_tgt0", 1'b1, 32'h100, 32'h104);
    @(negedge clk); #1;
    check_out("c_tgt1", 1'b1, 32'h104, 32'h108);
    @(negedge clk); #1;
    check_out("c_tgt2", 1'b1, 32'h108, 32'h10C);

    // ---- Redirect coinciding with a pop: pop ignored, queue empty next ----
    apply_reset();
    bus.out_ready = 1'b1;                     // cycle 0
    repeat (2) @(negedge clk);                // cycle 2
    @(negedge clk);                           // cycle 3
    bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0200; #1;
    check_out("d_head", 1'b1, 32'h4, 32'h8);
    check("d_redir_addr", bus.imem_addr, 32'h200);
    @(negedge clk);                           // cycle 4
    bus.redirect = 1'b0; #1;
    check_out("d_empty", 1'b0, 32'h0, 32'h0);
    check("d_c4_addr", bus.imem_addr, 32'h204);
    @(negedge clk); #1;
    check_out("d_tgt0", 1'b1, 32'h200, 32'h204);
    @(negedge clk); #1;
    check_out("d_tgt1", 1'b1, 32'h204, 32'h208);

    // ---- Redirect to an unaligned top-of-memory address: wrap to 0 ----
    apply_reset();
    bus.out_ready = 1'b1;                     // cycle 0
    @(negedge clk);                           // cycle 1
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFE; #1;
    check("e_redir_addr", bus.imem_addr, 32'hFFFF_FFFC);
    check("e_redir_req",  {31'b0, bus.imem_req}, 32'd1);
    @(negedge clk);                           // cycle 2
    bus.redirect = 1'b0; #1;
    check("e_wrap_addr", bus.imem_addr, 32'h0);
    check("e_c2_valid", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk); #1;
    check_out("e_top", 1'b1, 32'hFFFF_FFFC, 32'h0);
    @(negedge clk); #1;
    check_out("e_zero", 1'b1, 32'h0, 32'h4);

    // ---- Reset mid-stream with a request in flight ----
    apply_reset();
    bus.out_ready = 1'b1;                     // cycle 0
    repeat (2) @(negedge clk);                // cycle 2
    @(negedge clk);                           // cycle 3
    reset = 1'b1; #1;
    check("f_rst_req",  {31'b0, bus.imem_req}, 32'd0);
    check("f_rst_addr", bus.imem_addr, 32'h0);
    check_out("f_rst", 1'b0, 32'h0, 32'h0);
    @(negedge clk);                           // first cycle after release
    reset = 1'b0; #1;
    check_out("f_post0", 1'b0, 32'h0, 32'h0);
    check("f_post_req",  {31'b0, bus.imem_req}, 32'd1);
    check("f_post_addr", bus.imem_addr, 32'h0);
    @(negedge clk); #1;
    check_out("f_post1", 1'b0, 32'h0, 32'h0);
    @(negedge clk); #1;
    check_out("f_post2", 1'b1, 32'h0, 32'h4);
    @(negedge clk); #1;
    check_out("f_post3", 1'b1, 32'h4, 32'h8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
